// File: rtl/mic_add_pkg.sv
// Purpose: shared select encodings and A-mux constants for the microsequencer add slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mic_add_pkg;

    // A-mux select; any code with the top bit set routes the W-bus.
    localparam logic [2:0] ASRC_ZERO     = 3'b000;
    localparam logic [2:0] ASRC_ONE      = 3'b001;
    localparam logic [2:0] ASRC_TWO      = 3'b010;
    localparam logic [2:0] ASRC_FOUR     = 3'b011;
    localparam int         ASRC_WBUS_BIT = 2;

    // A-mux constant values (forced to zero in I-decode mode).
    localparam logic [2:0] ACONST_ZERO = 3'd0;
    localparam logic [2:0] ACONST_ONE  = 3'd1;
    localparam logic [2:0] ACONST_TWO  = 3'd2;
    localparam logic [2:0] ACONST_FOUR = 3'd4;

    // B-mux select.
    localparam logic [1:0] BSRC_ZERO    = 2'b00;
    localparam logic [1:0] BSRC_PC      = 2'b01;
    localparam logic [1:0] BSRC_VA_SAVE = 2'b10;
    localparam logic [1:0] BSRC_VA      = 2'b11;

    // MA-mux select.
    localparam logic [1:0] MASEL_INC = 2'b00;
    localparam logic [1:0] MASEL_TOP = 2'b01;
    localparam logic [1:0] MASEL_PC  = 2'b10;
    localparam logic [1:0] MASEL_VA  = 2'b11;

    // Constant driven onto the A operand for the non-W-bus select codes.
    function automatic logic [2:0] a_const(input logic [2:0] sel, input logic id_mode);
        logic [2:0] v;
        case (sel)
            ASRC_ONE:  v = ACONST_ONE;
            ASRC_TWO:  v = ACONST_TWO;
            ASRC_FOUR: v = ACONST_FOUR;
            default:   v = ACONST_ZERO;
        endcase
        return id_mode ? ACONST_ZERO : v;
    endfunction

endpackage

// File: rtl/mic_add_bkp_stack.sv
// Purpose: PC backup store; BKP_DEPTH-entry LIFO with MIC_ADD_BKP_STACK_EN, else one register.
// Latency: push/pop take effect on the next rising edge; top/empty/take are combinational.
// Backpressure: none; overflow drops the oldest entry, underflow is ignored, both flag err.
module mic_add_bkp_stack
    import mic_add_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BKP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             err,
    output logic             take
);

    if (BKP_DEPTH < 2 || BKP_DEPTH > 8) begin : g_bad_depth
        $error("mic_add_bkp_stack: BKP_DEPTH must be 2..8");
    end

    // A pop only hands a value to the PC when there is something to hand over.
    assign take = pop & ~empty;

`ifdef MIC_ADD_BKP_STACK_EN

    localparam int CW = $clog2(BKP_DEPTH + 1);

    // entry[0] is the top of stack; pushes shift toward the bottom so the
    // oldest entry falls off the end on overflow.
    logic [WIDTH-1:0] entry [BKP_DEPTH];
    logic [CW-1:0]    depth;
    logic             full;

    assign empty = (depth == '0);
    assign full  = (depth == CW'(BKP_DEPTH));
    assign top   = empty ? '0 : entry[0];

    // Stack contents, depth and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth <= '0;
            err   <= 1'b0;
            for (int i = 0; i < BKP_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (push && pop && !empty) begin
            // Swap: old top goes to the PC, old PC replaces the top.
            entry[0] <= pc;
        end else if (push) begin
            entry[0] <= pc;
            for (int i = 1; i < BKP_DEPTH; i++) begin
                entry[i] <= entry[i-1];
            end
            if (full) begin
                err <= 1'b1;
            end else begin
                depth <= depth + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                for (int i = 0; i < BKP_DEPTH - 1; i++) begin
                    entry[i] <= entry[i+1];
                end
                entry[BKP_DEPTH-1] <= '0;
                depth <= depth - 1'b1;
            end
        end
    end

`else

    // Single backup register: empty only until the first push, never errors.
    logic [WIDTH-1:0] saved;
    logic             valid;

    assign empty = ~valid;
    assign top   = saved;
    assign err   = 1'b0;

    // Push overwrites; a pop leaves the saved value in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            saved <= '0;
            valid <= 1'b0;
        end else if (push) begin
            saved <= pc;
            valid <= 1'b1;
        end
    end

`endif

endmodule

// File: rtl/mic_add_slice.sv
// Purpose: microsequencer address slice (A/B adder, VA/PC regs, PC incrementer, backup, MA reg); MIC_ADD_BKP_STACK_EN selects LIFO backup.
// Latency: VA/PC update on the edge; MA loads one edge after the latch request edge; flags combinational.
// Backpressure: none; every control input is acted on at each rising edge.
module mic_add_slice
    import mic_add_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BKP_DEPTH = 4,
    parameter int PAGE_BITS = 9
) (
    input  logic             b_clk_l,
    input  logic             reset_h,
    input  logic [WIDTH-1:0] wbus_h,
    input  logic             aci_l,
    input  logic [2:0]       asrc_sel_h,
    input  logic [1:0]       bsrc_sel_h,
    input  logic [1:0]       ma_select_h,
    input  logic             ena_va_l,
    input  logic             ena_va_save_l,
    input  logic             ena_pc_l,
    input  logic             push_bkp_l,
    input  logic             pop_bkp_l,
    input  logic             latch_ma_l,
    input  logic             force_ma_h,
    input  logic             comp_h,
    input  logic             id_h,
    input  logic             ici_l,
    output logic             ico_l,
    output logic             pgb_h,
    output logic [WIDTH-1:0] pc_h,
    output logic [WIDTH-1:0] va_h,
    output logic [WIDTH-1:0] ma_h,
    output logic             cp_h,
    output logic             cg_h,
    output logic             bkp_empty_h,
    output logic             bkp_err_h
);

    if (WIDTH < 8 || WIDTH > 32 || (WIDTH % 8) != 0) begin : g_bad_width
        $error("mic_add_slice: WIDTH must be a multiple of 8 in 8..32");
    end
    if (PAGE_BITS < 4 || PAGE_BITS > WIDTH) begin : g_bad_page
        $error("mic_add_slice: PAGE_BITS must be 4..WIDTH");
    end

    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] va_save;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ma_reg;
    logic             lma;

    logic [WIDTH-1:0] a_opnd;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   inc_step;
    logic [WIDTH:0]   inc;
    logic [WIDTH-1:0] ma_mux;

    logic [WIDTH-1:0] stk_top;
    logic             stk_take;

    // A operand: W-bus or a small constant.
    always_comb begin
        a_opnd = '0;
        if (asrc_sel_h[ASRC_WBUS_BIT]) begin
            a_opnd = wbus_h;
        end else begin
            a_opnd = {{(WIDTH-3){1'b0}}, a_const(asrc_sel_h, id_h)};
        end
    end

    // B operand: zero or one of the address registers.
    always_comb begin
        b_opnd = '0;
        case (bsrc_sel_h)
            BSRC_PC:      b_opnd = pc;
            BSRC_VA_SAVE: b_opnd = va_save;
            BSRC_VA:      b_opnd = va;
            default:      b_opnd = '0;
        endcase
    end

    // Adder keeps its carry-out so cg can flag both overflow and all-ones.
    assign sum  = {1'b0, a_opnd} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, ~aci_l};
    assign cp_h = |(a_opnd & b_opnd);
    assign cg_h = sum[WIDTH] | (&sum[WIDTH-1:0]);

    // Incrementer step: +4 outside I-decode mode plus the active-low carry-in.
    always_comb begin
        inc_step    = '0;
        inc_step[2] = ~id_h;
        inc_step[0] = ~ici_l;
    end

    assign inc   = {1'b0, pc} + inc_step;
    assign ico_l = ~inc[WIDTH];

    // Page boundary: low bit in I-decode mode, otherwise last word of the page.
    assign pgb_h = id_h ? va[0] : (&va[PAGE_BITS-1:3]);

    mic_add_bkp_stack #(
        .WIDTH     (WIDTH),
        .BKP_DEPTH (BKP_DEPTH)
    ) u_bkp (
        .clk   (b_clk_l),
        .reset (reset_h),
        .push  (~push_bkp_l),
        .pop   (~pop_bkp_l),
        .pc    (pc),
        .top   (stk_top),
        .empty (bkp_empty_h),
        .err   (bkp_err_h),
        .take  (stk_take)
    );

    // VA, VA-save and PC registers; a stack pop wins over the VA-save load.
    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            va      <= '0;
            va_save <= '0;
            pc      <= '0;
        end else begin
            if (!ena_va_l) begin
                va <= sum[WIDTH-1:0];
            end
            if (!ena_va_save_l) begin
                va_save <= sum[WIDTH-1:0];
            end
            if (stk_take) begin
                pc <= stk_top;
            end else if (!ena_pc_l) begin
                pc <= va_save;
            end
        end
    end

    // MA source select; comp forces a zero address.
    always_comb begin
        ma_mux = '0;
        if (!comp_h) begin
            case (ma_select_h)
                MASEL_INC: ma_mux = inc[WIDTH-1:0];
                MASEL_TOP: ma_mux = stk_top;
                MASEL_PC:  ma_mux = pc;
                default:   ma_mux = va;
            endcase
        end
    end

    // Latch request is registered, so the MA register loads one edge later.
    always_ff @(posedge b_clk_l) begin
        if (reset_h) begin
            lma    <= 1'b0;
            ma_reg <= '0;
        end else begin
            lma <= ~latch_ma_l;
            if (lma) begin
                ma_reg <= ma_mux;
            end
        end
    end

    assign ma_h = ma_reg | {{(WIDTH-2){1'b0}}, force_ma_h, 1'b0};
    assign pc_h = pc;
    assign va_h = va;

endmodule

// File: tb/tb_mic_add_slice.sv
// Purpose: self-checking bench for mic_add_slice; directed cases then random cycles vs a queue-based model.
// Latency: checks one time unit after each rising edge.
// Backpressure: n/a.
module tb_mic_add_slice;

    localparam int W = 16;
    localparam int D = 4;
`ifdef MIC_ADD_BKP_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  wbus;
    logic          aci_l;
    logic [2:0]    asrc;
    logic [1:0]    bsrc;
    logic [1:0]    masel;
    logic          ena_va_l, ena_vas_l, ena_pc_l;
    logic          push_l, pop_l, latch_l;
    logic          force_ma, comp, id, ici_l;

    logic          ico_l, pgb, cp, cg, empty, err;
    logic [W-1:0]  pc, va, ma;

    int vectors = 0;
    int miscompares = 0;

    // Reference state.
    logic [15:0] m_va, m_vas, m_pc, m_ma, m_reg;
    logic        m_lma, m_err, m_valid;
    logic [15:0] stk [$];

    always #5 clk = ~clk;

    mic_add_slice #(.WIDTH(W), .BKP_DEPTH(D), .PAGE_BITS(9)) dut (
        .b_clk_l       (clk),
        .reset_h       (rst),
        .wbus_h        (wbus),
        .aci_l         (aci_l),
        .asrc_sel_h    (asrc),
        .bsrc_sel_h    (bsrc),
        .ma_select_h   (masel),
        .ena_va_l      (ena_va_l),
        .ena_va_save_l (ena_vas_l),
        .ena_pc_l      (ena_pc_l),
        .push_bkp_l    (push_l),
        .pop_bkp_l     (pop_l),
        .latch_ma_l    (latch_l),
        .force_ma_h    (force_ma),
        .comp_h        (comp),
        .id_h          (id),
        .ici_l         (ici_l),
        .ico_l         (ico_l),
        .pgb_h         (pgb),
        .pc_h          (pc),
        .va_h          (va),
        .ma_h          (ma),
        .cp_h          (cp),
        .cg_h          (cg),
        .bkp_empty_h   (empty),
        .bkp_err_h     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int f_a();
        if (asrc[2]) return int'(wbus);
        if (id) return 0;
        case (asrc[1:0])
            2'd0:    return 0;
            2'd1:    return 1;
            2'd2:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int f_b();
        case (bsrc)
            2'd0:    return 0;
            2'd1:    return int'(m_pc);
            2'd2:    return int'(m_vas);
            default: return int'(m_va);
        endcase
    endfunction

    function automatic int f_sum();
        return f_a() + f_b() + (aci_l ? 0 : 1);
    endfunction

    function automatic int f_inc();
        return int'(m_pc) + (ici_l ? 0 : 1) + (id ? 0 : 4);
    endfunction

    function automatic bit f_empty();
        if (STK) return stk.size() == 0;
        return !m_valid;
    endfunction

    function automatic logic [15:0] f_top();
        if (!STK) return m_reg;
        if (stk.size() == 0) return 16'h0000;
        return stk[0];
    endfunction

    function automatic logic [15:0] f_mamux();
        int i;
        if (comp) return 16'h0000;
        i = f_inc();
        case (masel)
            2'd0:    return 16'(i);
            2'd1:    return f_top();
            2'd2:    return m_pc;
            default: return m_va;
        endcase
    endfunction

    task automatic check_all();
        int s;
        int i;
        s = f_sum();
        i = f_inc();
        chk("va", va, m_va);
        chk("pc", pc, m_pc);
        chk("ma", ma, m_ma | (force_ma ? 16'h0002 : 16'h0000));
        chk("bkp_empty", empty, f_empty());
        chk("bkp_err", err, m_err);
        chk("cg", cg, (s >= 65536) || ((s & 65535) == 65535));
        chk("cp", cp, (f_a() & f_b()) != 0);
        chk("ico_l", ico_l, i < 65536);
        chk("pgb", pgb, id ? m_va[0] : (((m_va >> 3) & 16'h003F) == 16'h003F));
    endtask

    // Advance the model by one edge using the currently driven inputs, then check.
    task automatic cycle();
        int          s;
        logic [15:0] mux, n_va, n_vas, n_pc;
        bit          popped;
        s      = f_sum();
        mux    = f_mamux();
        n_va   = m_va;
        n_vas  = m_vas;
        n_pc   = m_pc;
        popped = 1'b0;
        if (rst) begin
            n_va = 0; n_vas = 0; n_pc = 0;
            m_ma = 0; m_lma = 0; m_err = 0; m_valid = 0; m_reg = 0;
            stk.delete();
        end else begin
            if (!ena_va_l)  n_va  = 16'(s);
            if (!ena_vas_l) n_vas = 16'(s);
            if (STK) begin
                if (!push_l && !pop_l && stk.size() > 0) begin
                    n_pc = stk[0];
                    popped = 1'b1;
                    stk[0] = m_pc;
                end else if (!push_l) begin
                    if (stk.size() == D) begin
                        void'(stk.pop_back());
                        m_err = 1'b1;
                    end
                    stk.push_front(m_pc);
                end else if (!pop_l) begin
                    if (stk.size() == 0) m_err = 1'b1;
                    else begin
                        n_pc = stk.pop_front();
                        popped = 1'b1;
                    end
                end
            end else begin
                if (!pop_l && m_valid) begin
                    n_pc = m_reg;
                    popped = 1'b1;
                end
                if (!push_l) begin
                    m_reg = m_pc;
                    m_valid = 1'b1;
                end
            end
            if (!popped && !ena_pc_l) n_pc = m_vas;
            if (m_lma) m_ma = mux;
            m_lma = !latch_l;
        end
        m_va  = n_va;
        m_vas = n_vas;
        m_pc  = n_pc;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; wbus = 0; aci_l = 1; asrc = 0; bsrc = 0; masel = 0;
        ena_va_l = 1; ena_vas_l = 1; ena_pc_l = 1;
        push_l = 1; pop_l = 1; latch_l = 1;
        force_ma = 0; comp = 0; id = 0; ici_l = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        idle();
    endtask

    // Route a value through VA-save into the PC (two edges).
    task automatic load_pc(input logic [15:0] v);
        idle();
        asrc = 3'b100; wbus = v; ena_vas_l = 0;
        cycle();
        idle();
        ena_pc_l = 0;
        cycle();
        idle();
    endtask

    initial begin
        m_va = 0; m_vas = 0; m_pc = 0; m_ma = 0; m_reg = 0;
        m_lma = 0; m_err = 0; m_valid = 0;

        // Reset state, with the MA bit-1 force visible through reset.
        idle();
        rst = 1; force_ma = 1; ena_va_l = 0; asrc = 3'b100; wbus = 16'hBEEF;
        cycle();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_va", va, 16'h0000);
        chk("rst_ma", ma, 16'h0002);
        chk("rst_empty", empty, 1'b1);
        chk("rst_err", err, 1'b0);

        // Adder carry generate.
        idle();
        asrc = 3'b100; wbus = 16'h00FF; aci_l = 0; ena_va_l = 0;
        cycle();
        chk("add_va", va, 16'h0100);
        chk("add_cg0", cg, 1'b0);
        wbus = 16'hFFFF;
        #1;
        chk("add_cg1", cg, 1'b1);

        // Five pushes then five pops.
        do_reset();
        load_pc(16'h1234);
        push_l = 0;
        repeat (5) cycle();
        chk("push5_err", err, STK);
        chk("push5_empty", empty, 1'b0);
        load_pc(16'h5555);
        pop_l = 0;
        cycle();
        chk("pop1_pc", pc, 16'h1234);
        repeat (3) cycle();
        chk("pop4_empty", empty, STK);
        load_pc(16'h5555);
        pop_l = 0;
        cycle();
        chk("pop5_pc", pc, STK ? 16'h5555 : 16'h1234);

        // Simultaneous push and pop swaps PC and top.
        do_reset();
        load_pc(16'h0020);
        push_l = 0;
        cycle();
        load_pc(16'h0010);
        push_l = 0; pop_l = 0;
        cycle();
        chk("swap_pc", pc, 16'h0020);
        idle();
        masel = 2'b01; latch_l = 0;
        cycle();
        idle();
        masel = 2'b01;
        cycle();
        chk("swap_top", ma, 16'h0010);

        // MA latch latency and bit-1 force.
        do_reset();
        load_pc(16'h00AB);
        masel = 2'b10; latch_l = 0;
        cycle();
        chk("ma_edgeN", ma, 16'h0000);
        idle();
        masel = 2'b10;
        cycle();
        chk("ma_edgeN1", ma, 16'h00AB);
        force_ma = 1;
        #1;
        chk("ma_force", ma, 16'h00AB);

        // Incrementer wrap and page boundary.
        do_reset();
        load_pc(16'hFFFC);
        #1;
        chk("ico_wrap", ico_l, 1'b0);
        asrc = 3'b100; wbus = 16'h01F8; ena_va_l = 0;
        cycle();
        idle();
        #1;
        chk("pgb_page", pgb, 1'b1);
        id = 1;
        #1;
        chk("pgb_id", pgb, 1'b0);

        // Reset during a push at full.
        do_reset();
        load_pc(16'h0042);
        push_l = 0;
        repeat (5) cycle();
        rst = 1;
        cycle();
        chk("rstpush_empty", empty, 1'b1);
        chk("rstpush_err", err, 1'b0);

        // Random cycles.
        idle();
        repeat (500) begin
            rst       = ($urandom_range(0, 49) == 0);
            wbus      = 16'($urandom);
            aci_l     = 1'($urandom);
            asrc      = 3'($urandom);
            bsrc      = 2'($urandom);
            masel     = 2'($urandom);
            ena_va_l  = 1'($urandom);
            ena_vas_l = 1'($urandom);
            ena_pc_l  = ($urandom_range(0, 3) != 0);
            push_l    = ($urandom_range(0, 2) != 0);
            pop_l     = ($urandom_range(0, 2) != 0);
            latch_l   = 1'($urandom);
            force_ma  = 1'($urandom);
            comp      = ($urandom_range(0, 5) == 0);
            id        = ($urandom_range(0, 3) == 0);
            ici_l     = 1'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mic_add_slice.md
MIC_ADD_SLICE -- requirements
Module: mic_add_slice

Interface
REQ-001 SHALL have parameter WIDTH, 16, datapath width; a multiple of 8 in the range 8..32.
REQ-002 SHALL have parameter BKP_DEPTH, 4, PC-backup stack entries (2..8).
REQ-003 SHALL have parameter PAGE_BITS, 9, page-offset width used by pgb_h.
REQ-004 SHALL use one clock and a reset that is synchronous and active-high.
REQ-005 b_clk_l  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_h  in  1  synchronous active-high reset.
REQ-007 wbus_h  in  WIDTH  W-bus operand.
REQ-008 aci_l  in  1  adder carry-in, active low.
REQ-009 asrc_sel_h  in  3  A-mux select.
REQ-010 bsrc_sel_h  in  2  B-mux select.
REQ-011 ma_select_h  in  2  MA-mux select.
REQ-012 ena_va_l / ena_va_save_l / ena_pc_l  in  1 each  load enables, active low.
REQ-013 push_bkp_l / pop_bkp_l  in  1 each  backup push/pop, active low.
REQ-014 latch_ma_l  in  1  MA capture request, active low.
REQ-015 force_ma_h / comp_h / id_h  in  1 each  MA bit-1 force, MA zero, I-decode mode.
REQ-016 ici_l  in  1  incrementer carry-in, active low.
REQ-017 ico_l  out  1  incrementer carry-out, active low.
REQ-018 pgb_h  out  1  page-boundary flag.
REQ-019 pc_h / va_h  out  WIDTH each  PC and VA register contents.
REQ-020 ma_h  out  WIDTH  memory address.
REQ-021 cp_h / cg_h  out  1 each  carry propagate / carry generate.
REQ-022 bkp_empty_h / bkp_err_h  out  1 each  stack empty; sticky overflow/underflow error.

Function
REQ-023 A-mux SHALL select 000:0, 001:1, 010:2, 011:4, 1xx:wbus_h; constants SHALL be 0 when id_h=1.
REQ-024 B-mux SHALL select 00:0, 01:pc, 10:va_save, 11:va.
REQ-025 sum = A+B+~aci_l, width WIDTH+1; cp_h = |(A&B); cg_h = sum[WIDTH] | &sum[WIDTH-1:0].
REQ-026 On an edge with ena_va_l=0, va SHALL load sum; with ena_va_save_l=0, va_save SHALL load sum.
REQ-027 inc = pc + ~ici_l + (id_h ? 0 : 4), modulo 2^WIDTH; ico_l SHALL be the complement of the incrementer carry-out.
REQ-028 pgb_h SHALL equal va[0] when id_h=1, else &va[PAGE_BITS-1:3].
REQ-029 Push: captures current pc into the top of stack; push when full discards the oldest entry and sets bkp_err_h.
REQ-030 Pop: pc loads the top entry, which is removed; pop when empty leaves pc and the stack unchanged and sets bkp_err_h.
REQ-031 Simultaneous push and pop: pc loads the old top; the top is replaced by the old pc; depth unchanged; if empty, the push alone occurs.
REQ-032 pc load priority SHALL be pop over ena_pc_l (which loads va_save); both use pre-edge values.
REQ-033 MA-mux SHALL select comp_h=1:0; else 00:inc, 01:stack top (0 if empty), 10:pc, 11:va.
REQ-034 ~latch_ma_l SHALL be registered (lma); on an edge where lma=1, the MA register loads the MA-mux; latency is 1 cycle from request to load edge.
REQ-035 ma_h = MA register | (force_ma_h << 1), combinational.

Reset
REQ-036 reset_h=1 at an edge SHALL clear va, va_save, pc, the MA register, lma, the stack (empty), and bkp_err_h; ma_h SHALL equal force_ma_h<<1.
REQ-037 Reset SHALL override every concurrent load, push, or pop in the same cycle.

Configuration
REQ-038 With MIC_ADD_BKP_STACK_EN defined, the backup SHALL be a BKP_DEPTH-entry LIFO as specified above.
REQ-039 Without it, the backup SHALL be a single register: push overwrites without error; pop restores the register and never empties; bkp_err_h=0; bkp_empty_h=0 after the first push.

Structure
REQ-040 mic_add_pkg SHALL hold the A/B/MA select encodings and the A-mux constant values.
REQ-041 The stack SHALL be the sub-module mic_add_bkp_stack (parameters WIDTH, BKP_DEPTH).

Verification (WIDTH=16, BKP_DEPTH=4, PAGE_BITS=9)
REQ-042 asrc=1xx, wbus=0x00FF, bsrc=00, aci_l=0, ena_va_l=0 -> va=0x0100, cg_h=0 after edge; wbus=0xFFFF -> cg_h=1.
REQ-043 pc=0x1234, five pushes -> stack holds four entries, bkp_err_h=1; five pops -> fourth pop leaves empty, fifth pop leaves pc unchanged.
REQ-044 Push and pop together, pc=0x0010, top=0x0020 -> pc=0x0020, top=0x0010.
REQ-045 latch_ma_l low at edge N, ma_select=10, pc=0x00AB -> ma_h=0x00AB after edge N+1; force_ma_h=1 -> 0x00AB.
REQ-046 id_h=0, pc=0xFFFC, ici_l=1 -> inc=0x0000, ico_l=0; va=0x01F8 -> pgb_h=1.
REQ-047 reset_h during a push at full -> stack empty, bkp_err_h=0.
